// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Valid/ready pipeline stage register carrying a data payload and
//            a control bundle between two processor pipeline stages, with a
//            synchronous flush that kills every held entry.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   PIPE_STAGE_REG_SKID_EN  defined   -> two-entry skid buffer; IN_READY comes
//                                         straight from a flop.
//                           undefined -> single entry; IN_READY is
//                                         !OUT_VALID | OUT_READY.
// Ports:
//   CLK        in   1       rising-edge clock
//   RESET_N    in   1       asynchronous active-low reset
//   IN_VALID   in   1       upstream presents an entry
//   IN_READY   out  1       this stage accepts an entry this cycle
//   IN_DATA    in   DATA_W  upstream payload
//   IN_CTRL    in   CTRL_W  upstream control bundle
//   FLUSH      in   1       discard all held entries at the next edge
//   OUT_VALID  out  1       an entry is presented downstream
//   OUT_READY  in   1       downstream accepts the entry this cycle
//   OUT_DATA   out  DATA_W  head payload (holds last value while idle)
//   OUT_CTRL   out  CTRL_W  head control bundle, CTRL_BUBBLE while idle
//   OCCUPANCY  out  2       number of held entries
// ============================================================================
module pipe_stage_reg #(
    parameter int                DATA_W      = 32,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic [CTRL_W-1:0] IN_CTRL,
    input  logic              FLUSH,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [CTRL_W-1:0] OUT_CTRL,
    output logic [1:0]        OCCUPANCY
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1
`ifdef PIPE_STAGE_REG_SKID_EN
        ,
        S_TWO   = 2'd2
`endif
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_head_data;
    logic [CTRL_W-1:0]   r_head_ctrl;
    logic                w_in_xfer;
    logic                w_out_xfer;
    logic                w_load_in;

`ifdef PIPE_STAGE_REG_SKID_EN
    logic [DATA_W-1:0]   r_skid_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic                r_in_ready;
    logic                w_load_skid;
    logic                w_pop_skid;
`else
    logic                r_rst_done;
`endif

    assign OUT_VALID  = (r_state != S_EMPTY);
    assign OUT_DATA   = r_head_data;
    assign OUT_CTRL   = OUT_VALID ? r_head_ctrl : CTRL_BUBBLE;
    assign OCCUPANCY  = r_state;

`ifdef PIPE_STAGE_REG_SKID_EN
    assign IN_READY   = r_in_ready;
`else
    // r_rst_done keeps IN_READY low until the first edge after reset release.
    assign IN_READY   = r_rst_done & (~OUT_VALID | OUT_READY);
`endif

    assign w_in_xfer  = IN_VALID & IN_READY;
    assign w_out_xfer = OUT_VALID & OUT_READY;

    always_comb begin
        w_next_state = r_state;
        w_load_in    = 1'b0;
`ifdef PIPE_STAGE_REG_SKID_EN
        w_load_skid  = 1'b0;
        w_pop_skid   = 1'b0;
`endif
        case (r_state)
            S_EMPTY: begin
                if (w_in_xfer) begin
                    w_next_state = S_ONE;
                    w_load_in    = 1'b1;
                end
            end
            S_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_in    = 1'b1;
                end else if (w_out_xfer) begin
                    w_next_state = S_EMPTY;
`ifdef PIPE_STAGE_REG_SKID_EN
                end else if (w_in_xfer) begin
                    w_next_state = S_TWO;
                    w_load_skid  = 1'b1;
`endif
                end
            end
`ifdef PIPE_STAGE_REG_SKID_EN
            S_TWO: begin
                if (w_out_xfer) begin
                    w_next_state = S_ONE;
                    w_pop_skid   = 1'b1;
                end
            end
`endif
            default: w_next_state = S_EMPTY;
        endcase

        // Flush wins over everything; the head keeps its last value so
        // OUT_DATA stays put while the stage is idle.
        if (FLUSH) begin
            w_next_state = S_EMPTY;
            w_load_in    = 1'b0;
`ifdef PIPE_STAGE_REG_SKID_EN
            w_load_skid  = 1'b0;
            w_pop_skid   = 1'b0;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= S_EMPTY;
            r_head_data <= '0;
            r_head_ctrl <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load_in) begin
                r_head_data <= IN_DATA;
                r_head_ctrl <= IN_CTRL;
`ifdef PIPE_STAGE_REG_SKID_EN
            end else if (w_pop_skid) begin
                r_head_data <= r_skid_data;
                r_head_ctrl <= r_skid_ctrl;
`endif
            end
        end
    end

`ifdef PIPE_STAGE_REG_SKID_EN
    // Ready is registered from the next state so it never depends
    // combinationally on OUT_READY.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
            r_in_ready  <= 1'b0;
        end else begin
            r_in_ready <= (w_next_state != S_TWO);
            if (w_load_skid) begin
                r_skid_data <= IN_DATA;
                r_skid_ctrl <= IN_CTRL;
            end
        end
    end
`else
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Scoreboard bench for pipe_stage_reg. The driver pushes every
//            accepted entry into a queue; a separate monitor pops and
//            compares on each output transfer and watches hold stability,
//            the bubble value and ready behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam logic [15:0] CB = 16'h0BB0;
`ifdef PIPE_STAGE_REG_SKID_EN
    localparam logic [1:0]  FULL_OCC = 2'd2;
`else
    localparam logic [1:0]  FULL_OCC = 2'd1;
`endif

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] IN_DATA = '0;
    logic [15:0] IN_CTRL = '0;
    logic        FLUSH = 1'b0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [31:0] OUT_DATA;
    logic [15:0] OUT_CTRL;
    logic [1:0]  OCCUPANCY;

    pipe_stage_reg #(
        .DATA_W      (32),
        .CTRL_W      (16),
        .CTRL_BUBBLE (CB)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (IN_DATA),
        .IN_CTRL   (IN_CTRL),
        .FLUSH     (FLUSH),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_CTRL  (OUT_CTRL),
        .OCCUPANCY (OCCUPANCY)
    );

    always #5 CLK = ~CLK;

    logic [47:0] q[$];
    int          total = 0;
    int          bad   = 0;
    logic        chk_rdy = 1'b0;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One bus cycle: drive just after the rising edge, record acceptance
    // just after the falling edge (after the monitor has sampled).
    task automatic cycle(input logic v, input logic [31:0] d, input logic [15:0] c,
                         input logic ordy, input logic fl);
        @(posedge CLK);
        #1;
        IN_VALID  = v;
        IN_DATA   = d;
        IN_CTRL   = c;
        OUT_READY = ordy;
        FLUSH     = fl;
        @(negedge CLK);
        #1;
        if (fl) q.delete();
        else if (IN_VALID && IN_READY) q.push_back({IN_DATA, IN_CTRL});
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_out_valid"}, {47'd0, OUT_VALID}, 48'd0);
        chk({tag, "_out_data"},  {16'd0, OUT_DATA},  48'd0);
        chk({tag, "_out_ctrl"},  {32'd0, OUT_CTRL},  {32'd0, CB});
        chk({tag, "_occupancy"}, {46'd0, OCCUPANCY}, 48'd0);
        chk({tag, "_in_ready"},  {47'd0, IN_READY},  48'd0);
    endtask

    task automatic release_reset();
        @(negedge CLK);
        #2;
        RESET_N = 1'b1;
        chk("rdy_before_edge", {47'd0, IN_READY}, 48'd0);
        @(posedge CLK);
        #1;
        chk("rdy_after_edge", {47'd0, IN_READY}, 48'd1);
        chk_rdy = 1'b1;
    endtask

    // Monitor
    logic        p_hold = 1'b0;
    logic        p_valid;
    logic [31:0] p_data;
    logic [15:0] p_ctrl;

    always @(negedge CLK) begin
        logic [47:0] exp;
        if (!RESET_N) begin
            p_hold = 1'b0;
        end else begin
            if (p_hold) begin
                total++;
                if (OUT_VALID !== p_valid || OUT_DATA !== p_data || OUT_CTRL !== p_ctrl) begin
                    bad++;
                    $display("FAIL stable: got v=%0b d=%h c=%h want v=%0b d=%h c=%h",
                             OUT_VALID, OUT_DATA, OUT_CTRL, p_valid, p_data, p_ctrl);
                end
            end
            if (!OUT_VALID) begin
                total++;
                if (OUT_CTRL !== CB || OCCUPANCY !== 2'd0) begin
                    bad++;
                    $display("FAIL idle: got ctrl=%h occ=%0d want ctrl=%h occ=0", OUT_CTRL, OCCUPANCY, CB);
                end
            end
            if (chk_rdy) begin
                total++;
`ifdef PIPE_STAGE_REG_SKID_EN
                if (IN_READY !== (OCCUPANCY != 2'd2) || OCCUPANCY > 2'd2) begin
`else
                if (IN_READY !== (!OUT_VALID || OUT_READY) || OCCUPANCY > 2'd1) begin
`endif
                    bad++;
                    $display("FAIL ready: got rdy=%0b occ=%0d v=%0b ordy=%0b", IN_READY, OCCUPANCY, OUT_VALID, OUT_READY);
                end
            end
            if (OUT_VALID && OUT_READY) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out: got %h %h want none", OUT_DATA, OUT_CTRL);
                end else begin
                    exp = q.pop_front();
                    if ({OUT_DATA, OUT_CTRL} !== exp) begin
                        bad++;
                        $display("FAIL order: got %h want %h", {OUT_DATA, OUT_CTRL}, exp);
                    end
                end
            end
            p_hold  = OUT_VALID && !OUT_READY && !FLUSH;
            p_valid = OUT_VALID;
            p_data  = OUT_DATA;
            p_ctrl  = OUT_CTRL;
        end
    end

    initial begin
        // Power-on reset
        #3;
        chk_reset_values("por");
        release_reset();

        // First entry, one-cycle latency
        cycle(1'b1, 32'h11, 16'h00A5, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        chk("lat_valid", {47'd0, OUT_VALID}, 48'd1);
        chk("lat_data",  {16'd0, OUT_DATA},  48'h11);
        chk("lat_ctrl",  {32'd0, OUT_CTRL},  48'h00A5);

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, i, 16'(i + 16'h100), 1'b1, 1'b0);
            if (i > 1) chk("stream_occ", {46'd0, OCCUPANCY}, 48'd1);
        end
        cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        chk("stream_tail_occ", {46'd0, OCCUPANCY}, 48'd1);
        chk("stream_tail_data", {16'd0, OUT_DATA}, 48'h8);
        cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        chk("stream_empty", {47'd0, OUT_VALID}, 48'd0);
        chk("stream_hold_data", {16'd0, OUT_DATA}, 48'h8);

        // Backpressure: 0xA then 0xB with downstream stalled
        cycle(1'b1, 32'hA, 16'h000A, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 16'h000B, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 16'h000B, 1'b0, 1'b0);
        chk("bp_occ",   {46'd0, OCCUPANCY}, {46'd0, FULL_OCC});
        chk("bp_ready", {47'd0, IN_READY},  48'd0);
        chk("bp_data",  {16'd0, OUT_DATA},  48'hA);
`ifdef PIPE_STAGE_REG_SKID_EN
        cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
`else
        cycle(1'b1, 32'hB, 16'h000B, 1'b1, 1'b0);
`endif
        cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        chk("bp_second", {16'd0, OUT_DATA}, 48'hB);
        cycle(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        chk("bp_drained", {47'd0, OUT_VALID}, 48'd0);

        // Flush from full with a simultaneous input
        cycle(1'b1, 32'h21, 16'h0021, 1'b0, 1'b0);
        cycle(1'b1, 32'h22, 16'h0022, 1'b0, 1'b0);
        cycle(1'b1, 32'hC, 16'h000C, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        chk("flush_valid", {47'd0, OUT_VALID}, 48'd0);
        chk("flush_ctrl",  {32'd0, OUT_CTRL},  {32'd0, CB});
        chk("flush_occ",   {46'd0, OCCUPANCY}, 48'd0);
        chk("flush_hold",  {16'd0, OUT_DATA},  48'h21);

        // Flush while empty: the entry accepted that cycle is discarded
        cycle(1'b1, 32'hD, 16'h000D, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        chk("flush_empty_valid", {47'd0, OUT_VALID}, 48'd0);
        cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        chk("flush_empty_valid2", {47'd0, OUT_VALID}, 48'd0);

        // Asynchronous reset mid-cycle while full
        cycle(1'b1, 32'h31, 16'h0031, 1'b0, 1'b0);
        cycle(1'b1, 32'h32, 16'h0032, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        chk("pre_rst_occ", {46'd0, OCCUPANCY}, {46'd0, FULL_OCC});
        RESET_N  = 1'b0;
        chk_rdy  = 1'b0;
        IN_VALID = 1'b0;
        #1;
        chk_reset_values("async");
        q.delete();
        repeat (2) @(posedge CLK);
        release_reset();
        cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        chk("post_rst_valid", {47'd0, OUT_VALID}, 48'd0);

        // Random handshakes
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), 32'h1000_0000 + i, 16'(i) ^ 16'h5A5A,
                  ($urandom_range(0, 3) != 0), 1'b0);
        end
        repeat (4) cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        chk("final_queue_empty", 48'(q.size()), 48'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the data payload width in bits (range 1..256).
REQ-002 Parameter CTRL_W, default 16, SHALL set the control-signal bundle width in bits (range 1..64).
REQ-003 Parameter CTRL_BUBBLE, default 0 (CTRL_W bits), SHALL be the value driven on OUT_CTRL while no valid entry is presented.
REQ-004 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 RESET_N  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 IN_VALID  in  1  SHALL indicate that the upstream stage presents an entry.
REQ-007 IN_READY  out  1  SHALL indicate that the block accepts an entry this cycle.
REQ-008 IN_DATA  in  DATA_W  SHALL carry the upstream payload (operands, PC, immediate).
REQ-009 IN_CTRL  in  CTRL_W  SHALL carry the upstream control bundle (ALU op, mem read/write, reg-write enable/select).
REQ-010 FLUSH  in  1  SHALL be a synchronous request to discard all held entries.
REQ-011 OUT_VALID  out  1  SHALL indicate that the block presents an entry downstream.
REQ-012 OUT_READY  in  1  SHALL indicate that the downstream stage accepts the entry this cycle.
REQ-013 OUT_DATA  out  DATA_W  SHALL be the payload of the head entry.
REQ-014 OUT_CTRL  out  CTRL_W  SHALL be the control bundle of the head entry, or CTRL_BUBBLE when OUT_VALID=0.
REQ-015 OCCUPANCY  out  2  SHALL report the number of held entries (0..2).

Function
REQ-016 Input transfer SHALL occur iff IN_VALID=1 and IN_READY=1 at a rising edge; output transfer SHALL occur iff OUT_VALID=1 and OUT_READY=1.
REQ-017 Latency SHALL be exactly 1 cycle: an entry accepted into an empty block SHALL appear on OUT_* in the next cycle.
REQ-018 Entries SHALL leave in acceptance order, with no loss and no duplication.
REQ-019 The state machine SHALL have states EMPTY, ONE and TWO, with OCCUPANCY equal to 0, 1 and 2 respectively.
REQ-020 EMPTY: an input transfer SHALL move the state to ONE; otherwise the state SHALL remain EMPTY.
REQ-021 ONE: input and output transfers in the same cycle SHALL load the new entry into the head and stay in ONE; an input transfer alone SHALL capture the entry into the skid slot and move to TWO; an output transfer alone SHALL move to EMPTY.
REQ-022 TWO: IN_READY SHALL be 0; an output transfer SHALL move the skid entry to the head and the state to ONE.
REQ-023 In the skid build, IN_READY SHALL be driven directly from a flop with no combinational path from OUT_READY, and SHALL equal 1 in EMPTY and ONE.
REQ-024 FLUSH=1 SHALL force the state to EMPTY at the next edge; it SHALL take priority over any simultaneous input or output transfer, and an entry accepted in that cycle SHALL be discarded.
REQ-025 OUT_DATA SHALL hold its last head value while OUT_VALID=0.
REQ-026 OUT_VALID, OUT_DATA and OUT_CTRL SHALL remain stable while OUT_VALID=1 and OUT_READY=0.
REQ-027 IN_VALID=0 SHALL never change the held state, except through FLUSH or an output transfer.

Reset
REQ-028 When RESET_N=0 the block SHALL immediately set the state to EMPTY, OUT_VALID=0, OUT_DATA=0, OUT_CTRL=CTRL_BUBBLE, OCCUPANCY=0, skid contents=0, and IN_READY=0.
REQ-029 IN_READY SHALL become 1 on the first rising edge after RESET_N deasserts.
REQ-030 Reset asserted mid-transfer SHALL discard all entries, with no partial entry emitted afterwards.

Configuration
REQ-031 With macro PIPE_STAGE_REG_SKID_EN defined, the block SHALL implement the two-entry skid behaviour of REQ-019..REQ-023.
REQ-032 Without PIPE_STAGE_REG_SKID_EN, the block SHALL be a single entry: states EMPTY and ONE only, OCCUPANCY<=1, and IN_READY = !OUT_VALID | OUT_READY (combinational); all other requirements SHALL still hold.

Verification
REQ-033 Reset release, IN_VALID=1, IN_DATA=0x11, IN_CTRL=0x00A5, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_DATA=0x11, OUT_CTRL=0x00A5.
REQ-034 Stream 0x1..0x8 with OUT_READY=1 throughout -> one output per cycle, in order, OCCUPANCY constant at 1.
REQ-035 (SKID_EN) Accept 0xA then 0xB with OUT_READY=0 -> OCCUPANCY=2, IN_READY=0, OUT_DATA=0xA held; then OUT_READY=1 -> 0xA, then 0xB, with no loss.
REQ-036 Block in TWO, FLUSH=1 with IN_VALID=1 and IN_DATA=0xC -> next cycle OUT_VALID=0, OUT_CTRL=CTRL_BUBBLE, OCCUPANCY=0, and 0xC never emitted.
REQ-037 RESET_N pulled low asynchronously mid-cycle while OCCUPANCY=2 -> outputs reach reset values without a clock edge.
REQ-038 Random IN_VALID/OUT_READY for 10k cycles in both builds -> output sequence equals input sequence, and OUT_* stable whenever OUT_VALID=1 and OUT_READY=0.
